// File: rtl/div_pkg.sv
// div_pkg: shared constants and state encoding for the iterative divider.
//   WIDTH      operand width (fixed at 32 to match adder_cla)
//   CNT_W      iteration counter width
//   DIV_ITERS  number of CALC iterations
//   DIV_ZERO_Q quotient returned on divide-by-zero
package div_pkg;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned DIV_ITERS = 32;

   localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   // State encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CALC = ST_CALC,
      S_FIX  = ST_FIX
   } state_t;

endpackage

// File: rtl/adder_cla.sv
// adder_cla: 32-bit adder/subtractor built from generate/propagate terms.
//   a, b   operands
//   cin    carry in (1 with sub=1 gives a - b)
//   sub    1 = add the inverted b
//   s      0 = unsigned, 1 = signed (selects ov meaning)
//   sum    result
//   cout   carry out (for subtract: 1 = no borrow, a >= b)
//   ov     overflow for the selected signedness
module adder_cla
   import div_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             s,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ov
);

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH:0]   w_c;

   assign w_b_eff = sub ? ~b : b;
   assign w_g     = a & w_b_eff;
   assign w_p     = a ^ w_b_eff;

   // Carry chain from generate/propagate terms
   always_comb begin
      w_c    = '0;
      w_c[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
   end

   assign sum  = w_p ^ w_c[WIDTH-1:0];
   assign cout = w_c[WIDTH];
   // Signed: carry into vs out of MSB differ. Unsigned: carry (add) or borrow (sub).
   assign ov   = s ? (w_c[WIDTH] ^ w_c[WIDTH-1]) : (w_c[WIDTH] ^ sub);

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider (DIV/DIVU) for the execute stage.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request pulse, sampled only in IDLE
//   s                0 = unsigned, 1 = signed
//   dividend/divisor operands, captured on accepted start
//   busy             high from the cycle after accept until done
//   done             one-cycle pulse, results valid from this cycle
//   quotient         LO result, held until next accepted start
//   remainder        HI result, held until next accepted start
//   div_zero         divisor was zero, held with the results
// Optional build macro DIV_EARLY_OUT_EN: skip CALC when the divisor is zero
// or its magnitude exceeds the dividend magnitude (done at cycle 2).
module div_iter
   import div_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             s,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   // Two's-complement negate
   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   // Magnitude of v, treating it as signed only when sgn is set
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? neg_f(v) : v;
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dsor_mag;
   logic [WIDTH-1:0] r_dividend;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;
`ifdef DIV_EARLY_OUT_EN
   logic             r_early;
`endif

   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsor_mag;
   logic [WIDTH-1:0] w_rem_sh;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_accept;
   logic             w_ov_unused;

   assign w_dvd_mag  = mag_f(dividend, s);
   assign w_dsor_mag = mag_f(divisor, s);

   // Low 32 bits of the shifted partial remainder; its bit 32 is r_rem[MSB]
   assign w_rem_sh = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

   // Trial subtraction: w_rem_sh - divisor magnitude
   adder_cla u_adder (
      .a    (w_rem_sh),
      .b    (r_dsor_mag),
      .cin  (1'b1),
      .sub  (1'b1),
      .s    (1'b0),
      .sum  (w_sum),
      .cout (w_cout),
      .ov   (w_ov_unused)
   );

   // A set shifted-out bit means the 33-bit partial remainder already exceeds the divisor
   assign w_accept = r_rem[WIDTH-1] | w_cout;

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dsor_mag <= '0;
         r_dividend <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
         r_early    <= 1'b0;
`endif
         busy       <= 1'b0;
         done       <= 1'b0;
         quotient   <= '0;
         remainder  <= '0;
         div_zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dividend <= dividend;
                  r_dsor_mag <= w_dsor_mag;
                  r_rem      <= '0;
                  r_quo      <= w_dvd_mag;
                  r_neg_q    <= s & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_r    <= s & dividend[WIDTH-1];
                  r_dz       <= (divisor == '0);
                  r_cnt      <= '0;
                  busy       <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                  r_early    <= (w_dsor_mag > w_dvd_mag);
                  r_state    <= ((divisor == '0) || (w_dsor_mag > w_dvd_mag)) ? S_FIX : S_CALC;
`else
                  r_state    <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               r_rem <= w_accept ? w_sum : w_rem_sh;
               r_quo <= {r_quo[WIDTH-2:0], w_accept};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               busy     <= 1'b0;
               done     <= 1'b1;
               div_zero <= r_dz;
               if (r_dz) begin
                  quotient  <= DIV_ZERO_Q;
                  remainder <= r_dividend;
               end
`ifdef DIV_EARLY_OUT_EN
               else if (r_early) begin
                  quotient  <= '0;
                  remainder <= r_dividend;
               end
`endif
               else begin
                  quotient  <= r_neg_q ? neg_f(r_quo) : r_quo;
                  remainder <= r_neg_r ? neg_f(r_rem) : r_rem;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
